// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, default latencies, FSM state type.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef logic md_state_t;
    localparam md_state_t ST_IDLE = 1'b0;
    localparam md_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/muldiv_calc.sv
// Combinational 32x32 multiply / divide producing the 64-bit {hi,lo} result and a divide-by-zero flag.
module muldiv_calc
    import muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div0
);

    logic        is_signed;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        is_div    = (op == MD_DIV)  || (op == MD_DIVU);

        // Low 64 bits of the extended product equal the signed product when sign-extended.
        ext_a = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        ext_b = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        prod  = ext_a * ext_b;

        // Divide on magnitudes, then restore signs (quotient toward zero, remainder follows dividend).
        neg_a   = is_signed & a[31];
        neg_b   = is_signed & b[31];
        mag_a   = neg_a ? -a : a;
        mag_b   = neg_b ? -b : b;
        div0    = is_div && (b == 32'd0);
        divisor = (b == 32'd0) ? 32'd1 : mag_b;
        uq      = mag_a / divisor;
        ur      = mag_a % divisor;
        q       = (neg_a ^ neg_b) ? -uq : uq;
        r       = neg_a ? -ur : ur;

        result  = is_div ? {r, q} : prod;
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit: fixed-latency MULT/DIV with HI/LO ownership and MTHI/MTLO writes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        wr,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_t   state;
    logic [CW-1:0] cnt;
    logic [63:0] pend;
    logic        pend_div0;
    logic [63:0] calc_res;
    logic        calc_div0;

    muldiv_calc u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (calc_res),
        .div0   (calc_div0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            pend      <= '0;
            pend_div0 <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // An accepted start masks any same-cycle MTHI/MTLO.
                    if (start && !cancel) begin
                        if (!op[2]) begin
                            pend      <= calc_res;
                            pend_div0 <= calc_div0;
                            cnt       <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            busy      <= 1'b1;
                            state     <= ST_RUN;
                        end
                    end else if (wr && !cancel) begin
                        if (op == MD_MTHI) hi <= a;
                        else if (op == MD_MTLO) lo <= a;
                    end
                end
                ST_RUN: begin
                    if (cnt == CW'(1)) begin
                        if (!pend_div0) {hi, lo} <= pend;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, wr, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .wr     (wr),
        .cancel (cancel),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one completed operation on HI/LO.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            MD_MULT:  begin sp = sx * sy; {exp_hi, exp_lo} = sp; end
            MD_MULTU: begin up = ux * uy; {exp_hi, exp_lo} = up; end
            MD_DIV:   if (y != 0) begin
                          sq = sx / sy; sr = sx % sy;
                          exp_lo = sq[31:0]; exp_hi = sr[31:0];
                      end
            MD_DIVU:  if (y != 0) begin
                          uq = ux / uy; ur = ux % uy;
                          exp_lo = uq[31:0]; exp_hi = ur[31:0];
                      end
            MD_MTHI:  exp_hi = x;
            MD_MTLO:  exp_lo = x;
            default:  ;
        endcase
    endfunction

    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit with_wr, input bit disturb);
        int n;
        int want;
        start = 1'b1; op = o; a = x; b = y; wr = with_wr;
        tick;
        start = 1'b0; wr = 1'b0;
        want = o[1] ? DC : MC;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (disturb && n == 1) begin wr = 1'b1; op = MD_MTHI; a = 32'hDEADBEEF; end
            if (disturb && n == 2) begin wr = 1'b0; start = 1'b1; op = MD_MULT; a = 32'd1; b = 32'd1; end
            if (disturb && n == 3) start = 1'b0;
            tick;
        end
        start = 1'b0; wr = 1'b0;
        model(o, x, y);
        check({tag, "/busy_cycles"}, 64'(n), 64'(want));
        check({tag, "/hi"}, {32'b0, hi}, {32'b0, exp_hi});
        check({tag, "/lo"}, {32'b0, lo}, {32'b0, exp_lo});
    endtask

    task automatic run_wr(input string tag, input logic [2:0] o, input logic [31:0] x);
        wr = 1'b1; op = o; a = x;
        tick;
        wr = 1'b0;
        model(o, x, 32'd0);
        check({tag, "/busy"}, {63'b0, busy}, 64'd0);
        check({tag, "/hi"}, {32'b0, hi}, {32'b0, exp_hi});
        check({tag, "/lo"}, {32'b0, lo}, {32'b0, exp_lo});
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        reset = 1'b1; start = 1'b0; wr = 1'b0; cancel = 1'b0;
        op = 3'd0; a = 32'd0; b = 32'd0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        tick; tick;
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick;
            check("reset/busy", {63'b0, busy}, 64'd0);
            check("reset/hi", {32'b0, hi}, 64'd0);
            check("reset/lo", {32'b0, lo}, 64'd0);
        end

        run_md("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        check("mult_neg/hi_const", {32'b0, hi}, 64'hFFFFFFFF);
        check("mult_neg/lo_const", {32'b0, lo}, 64'hFFFFFFFA);
        run_md("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        check("multu/hi_const", {32'b0, hi}, 64'h00000002);

        run_md("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        check("div_neg/lo_const", {32'b0, lo}, 64'hFFFFFFFD);
        check("div_neg/hi_const", {32'b0, hi}, 64'hFFFFFFFF);
        run_md("divu_zero", MD_DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
        check("divu_zero/lo_const", {32'b0, lo}, 64'hFFFFFFFD);

        run_md("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("div_ovf/lo_const", {32'b0, lo}, 64'h80000000);
        check("div_ovf/hi_const", {32'b0, hi}, 64'h0);

        run_wr("mtlo", MD_MTLO, 32'h12345678);
        check("mtlo/lo_const", {32'b0, lo}, 64'h12345678);

        run_md("mult_disturb", MD_MULT, 32'd7, 32'd9, 1'b0, 1'b1);
        check("mult_disturb/lo_const", {32'b0, lo}, 64'd63);
        tick;
        check("mult_disturb/idle_after", {63'b0, busy}, 64'd0);

        start = 1'b1; cancel = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd3;
        tick;
        start = 1'b0; cancel = 1'b0;
        check("cancel/busy", {63'b0, busy}, 64'd0);
        tick;
        check("cancel/busy2", {63'b0, busy}, 64'd0);
        check("cancel/hi", {32'b0, hi}, {32'b0, exp_hi});
        check("cancel/lo", {32'b0, lo}, {32'b0, exp_lo});

        run_md("start_wr", MD_MULT, 32'd2, 32'd2, 1'b1, 1'b0);
        check("start_wr/lo_const", {32'b0, lo}, 64'd4);

        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0;
        tick; tick;
        check("abort/busy_c3", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("abort/busy", {63'b0, busy}, 64'd0);
        check("abort/hi", {32'b0, hi}, 64'd0);
        check("abort/lo", {32'b0, lo}, 64'd0);
        run_md("post_abort", MD_MULT, 32'd4, 32'd5, 1'b0, 1'b0);
        check("post_abort/lo_const", {32'b0, lo}, 64'd20);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 20));
                2:       ry = -32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            if (!ro[2]) run_md($sformatf("rnd%0d", i), ro, rx, ry, 1'b0, 1'b0);
            else        run_wr($sformatf("rnd%0d", i), ro, rx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
